uart_rx_words: RTL

- UART receiver, 8N1, LSB first. Reassembles received bytes into 32-bit little-endian words and emits one word per 4 accepted bytes, with a word index.
- Counterpart of the team's UART/array transmitter: accepts exactly the byte stream that block produces for a NUM_WORDS x 32-bit array, byte 0 = word0[7:0].
- Sits in top on the uart_rx pin and feeds word writes into the u/du state arrays (host loads initial conditions).

---
 rtl/uart_rx_words.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_words.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_words
// Brief    : 8N1 UART receiver that packs bytes into little-endian 32-bit words
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_words #(
  parameter int CLKS_PER_BIT = 235,
  parameter int NUM_WORDS    = 100,
  parameter int IDX_W        = 7,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic [31:0]      word_data,
  output logic [IDX_W-1:0] word_index,
  output logic             word_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   c_last_word = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic [c_cnt_w-1:0]  r_clk_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic [1:0]          r_byte_cnt;
  logic [IDX_W-1:0]    r_word_cnt;
  logic [31:0]         r_word_buf;
  logic [c_to_w-1:0]   r_to_cnt;
  logic [31:0]         r_word_data;
  logic [IDX_W-1:0]    r_word_index;
  logic                r_word_valid;
  logic                r_frame_done;
  logic                r_frame_err;

  logic                w_bit_tick;
  logic                w_byte_ok;
  logic                w_byte_bad;
  logic                w_cnt_clr;
  logic                w_cnt_run;
  logic                w_to_run;
  logic                w_to_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_tick   = 1'b0;
    w_byte_ok    = 1'b0;
    w_byte_bad   = 1'b0;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_state_next = S_START;
      // A start bit that is gone by mid-bit is a glitch, not a frame.
      S_START: if (r_clk_cnt == c_half_last) w_state_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (r_clk_cnt == c_bit_last) begin
          w_bit_tick = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == c_bit_last) begin
          if (r_rx_s) begin
            w_byte_ok    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_byte_bad   = 1'b1;
            w_state_next = S_RECOVER;
          end
        end
      end
      S_RECOVER: if (r_rx_s) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_cnt_run   = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_cnt_clr   = (w_state_next != r_state) || w_bit_tick;
  assign w_to_run    = (r_state == S_IDLE) && r_rx_s && ((r_byte_cnt != 2'd0) || (r_word_cnt != '0));
  assign w_to_expire = w_to_run && (r_to_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_cnt   <= 2'd0;
      r_word_cnt   <= '0;
      r_word_buf   <= 32'd0;
      r_to_cnt     <= '0;
      r_word_data  <= 32'd0;
      r_word_index <= '0;
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= w_byte_bad;

      if (w_cnt_run && !w_cnt_clr) r_clk_cnt <= r_clk_cnt + c_cnt_w'(1);
      else                         r_clk_cnt <= '0;

      if (r_state != S_DATA) r_bit_idx <= 3'd0;
      else if (w_bit_tick)   r_bit_idx <= r_bit_idx + 3'd1;

      // LSB arrives first, so shifting right leaves the byte in natural order.
      if (w_bit_tick) r_shift <= {r_rx_s, r_shift[7:1]};

      if (w_byte_bad) begin
        r_byte_cnt <= 2'd0;
        r_word_cnt <= '0;
      end else if (w_byte_ok) begin
        r_word_buf[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_word_data  <= {r_shift, r_word_buf[23:0]};
          r_word_index <= r_word_cnt;
          r_word_valid <= 1'b1;
          if (r_word_cnt == c_last_word) begin
            r_frame_done <= 1'b1;
            r_word_cnt   <= '0;
          end else begin
            r_word_cnt <= r_word_cnt + IDX_W'(1);
          end
        end
      end else if (w_to_expire) begin
        r_byte_cnt <= 2'd0;
        r_word_cnt <= '0;
      end

      if (w_to_run && !w_to_expire) r_to_cnt <= r_to_cnt + c_to_w'(1);
      else                          r_to_cnt <= '0;
    end
  end

  assign word_data  = r_word_data;
  assign word_index = r_word_index;
  assign word_valid = r_word_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
